// File: rtl/seg_countdown_timer.sv
// Six-digit BCD countdown timer with load/start/pause control.
// Counts down once every CLK_FREQ/TICK_HZ cycles and pulses done on reaching zero.
module seg_countdown_timer #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int TICK_HZ  = 100
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        load,
   input  logic [23:0] load_val,
   input  logic        start,
   input  logic        pause,
   output logic [23:0] bcd_value,
   output logic        running,
   output logic        count_down,
   output logic        done
);

   localparam int DIV = CLK_FREQ / TICK_HZ;
   localparam int PW  = $clog2(DIV);
   localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t        state_reg, state_next;
   logic [PW-1:0] prescale_reg, prescale_next;
   logic [23:0]   value_reg, value_next;
   logic          running_reg, count_down_reg, done_reg;
   logic          count_down_next, done_next;

   logic [23:0]   dec_value;
   logic [23:0]   clamp_value;
   logic [5:0]    borrow;
   logic          tick;

   assign tick      = (state_reg == RUN) && (prescale_reg == PRE_MAX) && (value_reg != 24'd0);
   assign borrow[0] = 1'b1;

   // Ripple-borrow BCD decrement; load digits above 9 saturate to 9.
   generate
      for (genvar gi = 0; gi < 6; gi++) begin : g_digit
         logic [3:0] digit;
         logic [3:0] in_digit;
         assign digit     = value_reg[gi*4 +: 4];
         assign in_digit  = load_val[gi*4 +: 4];
         assign dec_value[gi*4 +: 4] = !borrow[gi]      ? digit :
                                       (digit == 4'd0)  ? 4'd9  : digit - 4'd1;
         assign clamp_value[gi*4 +: 4] = (in_digit > 4'd9) ? 4'd9 : in_digit;
         if (gi < 5) begin : g_borrow
            assign borrow[gi+1] = borrow[gi] && (digit == 4'd0);
         end
      end
   endgenerate

   always_comb begin
      state_next      = state_reg;
      prescale_next   = prescale_reg;
      value_next      = value_reg;
      count_down_next = 1'b0;
      done_next       = 1'b0;
      if (load) begin
         value_next    = clamp_value;
         state_next    = IDLE;
         prescale_next = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               prescale_next = '0;
               if (start) state_next = (value_reg != 24'd0) ? RUN : DONE;
            end
            RUN: begin
               // A coincident start outranks pause, and start is a no-op in RUN.
               if (tick) begin
                  prescale_next   = '0;
                  value_next      = dec_value;
                  count_down_next = 1'b1;
                  if (dec_value == 24'd0)      state_next = DONE;
                  else if (pause && !start)    state_next = PAUSE;
               end else begin
                  prescale_next = prescale_reg + PW'(1);
                  if (pause && !start) state_next = PAUSE;
               end
            end
            PAUSE: begin
               if (start) state_next = RUN;
            end
            DONE: begin
               prescale_next = '0;
               done_next     = 1'b1;
               state_next    = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg      <= IDLE;
         prescale_reg   <= '0;
         value_reg      <= '0;
         running_reg    <= 1'b0;
         count_down_reg <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         prescale_reg   <= prescale_next;
         value_reg      <= value_next;
         running_reg    <= (state_next == RUN);
         count_down_reg <= count_down_next;
         done_reg       <= done_next;
      end
   end

   assign bcd_value  = value_reg;
   assign running    = running_reg;
   assign count_down = count_down_reg;
   assign done       = done_reg;

endmodule

// File: doc/seg_countdown_timer.md
SEG_COUNTDOWN_TIMER -- requirements
Module: seg_countdown_timer

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100, decrement rate in Hz; DIV = CLK_FREQ/TICK_HZ, integer, >= 2.
REQ-003 SHALL have port sys_clk  input  1  the single clock; all logic rising-edge.
REQ-004 SHALL have port sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port load  input  1  one-cycle pulse; latches load_val.
REQ-006 SHALL have port load_val  input  24  six BCD digits; [23:20] most significant.
REQ-007 SHALL have port start  input  1  one-cycle pulse; begins or resumes counting.
REQ-008 SHALL have port pause  input  1  one-cycle pulse; freezes counting.
REQ-009 SHALL have port bcd_value  output  24  current count, six BCD digits, feeds the segment display driver.
REQ-010 SHALL have port running  output  1  high while in RUN.
REQ-011 SHALL have port count_down  output  1  one-cycle pulse on each decrement.
REQ-012 SHALL have port done  output  1  one-cycle pulse when the count reaches zero.

Function
REQ-013 SHALL implement states IDLE, RUN, PAUSE, DONE; all outputs registered.
REQ-014 SHALL run a prescaler 0..DIV-1 in RUN only; tick when prescaler = DIV-1, prescaler then wraps to 0.
REQ-015 SHALL clear the prescaler on IDLE->RUN and on load; hold it in PAUSE; resume from the held value on PAUSE->RUN.
REQ-016 SHALL, on tick, decrement bcd_value by one in BCD: a digit at 0 becomes 9 and borrows from the next digit; assert count_down the following cycle.
REQ-017 SHALL, on a tick whose result is 000000, go to DONE; DONE lasts exactly one cycle with done=1, then IDLE.
REQ-018 SHALL never decrement below 000000; no wrap to 999999.
REQ-019 SHALL, on load in any state, set bcd_value to load_val (next cycle), go to IDLE, clear prescaler, suppress done.
REQ-020 SHALL clamp each load_val digit greater than 9 to 9 at load.
REQ-021 SHALL, on start in IDLE with bcd_value != 0, go to RUN; with bcd_value = 0, go to DONE (done pulse, no decrement).
REQ-022 SHALL, on start in PAUSE, go to RUN; start in RUN or DONE is ignored.
REQ-023 SHALL, on pause in RUN, go to PAUSE; pause in other states is ignored.
REQ-024 SHALL apply priority load > start > pause when pulses coincide.
REQ-025 SHALL, when tick and pause coincide in RUN, apply the decrement, then enter PAUSE (or DONE if the result is 0).
REQ-026 SHALL make the first decrement exactly DIV cycles after the start pulse is sampled from IDLE.
REQ-027 SHALL hold bcd_value in IDLE, PAUSE and DONE.

Reset
REQ-028 SHALL, on sys_rst_n low, asynchronously set state IDLE, prescaler 0, bcd_value 000000, running 0, count_down 0, done 0.
REQ-029 SHALL resume normal operation on the first rising edge after sys_rst_n deasserts; no pulses generated by reset release.

Verification (CLK_FREQ=1000, TICK_HZ=100, DIV=10)
REQ-030 SHALL cover: load 000003, start -> count_down pulses 10, 20, 30 cycles after start; bcd_value 000002/000001/000000; done one cycle after the 000000 update; running 0 after.
REQ-031 SHALL cover: load 010000, start, one tick -> bcd_value 009999, no done.
REQ-032 SHALL cover: load 000005, start, pause at cycle 15, start at cycle 40 -> value 000004 held over 15..40; next decrement 5 cycles after restart.
REQ-033 SHALL cover: load 000009, start, load 000002 at cycle 25 -> state IDLE, bcd_value 000002, no done, no further decrements until start.
REQ-034 SHALL cover: load 0000A5 -> bcd_value 000095; load 000000, start -> done pulse next cycle, zero count_down pulses.
REQ-035 SHALL cover: sys_rst_n low mid-RUN, asynchronous to sys_clk -> all outputs 0 immediately, state IDLE after release.
